// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one divider among NREQ requesters, with local divide-by-zero and a watchdog
module divider_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic [1:0]            rsp_status,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [PW-1:0] ptr, g, gi;
  logic [WIDTH-1:0] dvd, dvs, q, r, sel_a, sel_b;
  logic [CW-1:0] cnt;
  logic [1:0] st;
  logic any;
  always_comb begin
    gi = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[PW'((int'(ptr) + k) % NREQ)]) gi = PW'((int'(ptr) + k) % NREQ);
  end
  assign any = |req_valid;
  assign sel_a = req_dividend[int'(gi)*WIDTH +: WIDTH];
  assign sel_b = req_divisor[int'(gi)*WIDTH +: WIDTH];
  // ready is gated by rst_n so it drops the instant reset is asserted
  assign req_ready = (rst_n && state == IDLE && any) ? NREQ'(1) << gi : '0;
  assign rsp_valid = (state == RESP) ? NREQ'(1) << g : '0;
  assign div_start = state == ISSUE;
  assign div_dividend = dvd;
  assign div_divisor = dvs;
  assign rsp_quotient = q;
  assign rsp_remainder = r;
  assign rsp_status = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      dvd <= '0;
      dvs <= '0;
      cnt <= '0;
      q <= '0;
      r <= '0;
      st <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          g <= gi;
          dvd <= sel_a;
          dvs <= sel_b;
          if (sel_b == '0) begin
            q <= '1;
            r <= sel_a;
            st <= 2'b01;
            state <= RESP;
          end else state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (div_done) begin
          q <= div_quotient;
          r <= div_remainder;
          st <= 2'b00;
          state <= RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          q <= '0;
          r <= '0;
          st <= 2'b10;
          state <= RESP;
        end else cnt <= cnt + CW'(1);
        RESP: begin
          ptr <= (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
